serial_rx_uart: RTL and testbench

- Receives asynchronous 8N1 serial bytes on the host serial input pin (serial_rx) and presents them on a byte-wide valid/ready interface to the game's command logic.
- Counterpart of the serial_tx path driven by the top level.
- Runs entirely in the ~65 MHz pixel clock domain.
- Bit timing comes from a single clocks-per-bit divisor.

---
 rtl/serial_pkg.sv | 16 +
 rtl/serial_rx_uart_sync2.sv | 24 ++
 rtl/serial_rx_uart.sv | 140 ++++++++++++++
 tb/tb_serial_rx_uart.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_pkg.sv
// Shared definitions for the serial receive path: receiver state encoding
// and default frame/bit-timing constants.
package serial_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } rx_state_t;

    localparam int DEFAULT_DIVISOR = 564;
    localparam int FRAME_BITS      = 8;

endpackage

// File: rtl/serial_rx_uart_sync2.sv
// Generic two-flop synchronizer for a single asynchronous input pin.
// RESET_VALUE should match the pin's idle level so reset produces no false edge.
module sync2 #(
    parameter logic RESET_VALUE = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= RESET_VALUE;
            q    <= RESET_VALUE;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/serial_rx_uart.sv
// 8N1 serial receiver: mid-bit sampling from a single clocks-per-bit divisor,
// delivering bytes through a one-entry holding register with valid/ready.
module serial_rx_uart
    import serial_pkg::*;
#(
    parameter int DIVISOR = DEFAULT_DIVISOR
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       serial_rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       overrun
);

    localparam int HALF = DIVISOR / 2;
    localparam int CW   = $clog2(DIVISOR);
    localparam int BW   = $clog2(FRAME_BITS);

    localparam logic [CW-1:0] CNT_FULL = CW'(DIVISOR - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(HALF - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(FRAME_BITS - 1);

    logic                  rxs;
    rx_state_t             state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [BW-1:0]         bitidx_q, bitidx_d;
    logic [FRAME_BITS-1:0] sr_q, sr_d;
    logic                  tick;
    logic                  byte_done;
    logic                  stop_bad;

    sync2 #(
        .RESET_VALUE(1'b1)
    ) u_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .d    (serial_rx),
        .q    (rxs)
    );

    assign tick = (cnt_q == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            bitidx_q <= '0;
            sr_q     <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bitidx_q <= bitidx_d;
            sr_q     <= sr_d;
        end
    end

    // The counter free-runs down in every active state and reloads on each
    // tick, so every sample lands one full bit after the start mid-point.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bitidx_d  = bitidx_q;
        sr_d      = sr_q;
        byte_done = 1'b0;
        stop_bad  = 1'b0;

        if (state_q != IDLE && !tick) begin
            cnt_d = cnt_q - CW'(1);
        end

        case (state_q)
            IDLE: begin
                if (!rxs) begin
                    cnt_d   = CNT_HALF;
                    state_d = START;
                end
            end
            START: begin
                if (tick) begin
                    if (rxs) begin
                        state_d = IDLE;
                    end else begin
                        cnt_d    = CNT_FULL;
                        bitidx_d = '0;
                        state_d  = DATA;
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    sr_d     = {rxs, sr_q[FRAME_BITS-1:1]};
                    cnt_d    = CNT_FULL;
                    bitidx_d = bitidx_q + BW'(1);
                    if (bitidx_q == BIT_LAST) begin
                        state_d = STOP;
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    byte_done = rxs;
                    stop_bad  = !rxs;
                    state_d   = rxs ? IDLE : BREAK;
                end
            end
            BREAK: begin
                if (rxs) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // A consumer taking the old byte in the completion cycle frees the slot,
    // so the new byte lands without a gap in rx_valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= stop_bad;
            overrun   <= byte_done && rx_valid && !rx_ready;
            if (byte_done && (!rx_valid || rx_ready)) begin
                rx_data  <= sr_q;
                rx_valid <= 1'b1;
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_serial_rx_uart.sv
// Randomised and directed bench for serial_rx_uart, compared every cycle
// against a frame-level model of the holding register and error pulses.
module tb_serial_rx_uart;

    localparam int D        = 16;
    localparam int H        = D / 2;
    localparam int TICK_OFS = 3 + H + 9 * D;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       serial_rx;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       frame_err;
    logic       overrun;

    typedef struct {
        int         t;
        bit         err;
        logic [7:0] d;
    } ev_t;

    ev_t        evq[$];
    ev_t        mev;
    bit         mdel;
    int         cyc = 0;
    int         tests = 0;
    int         fails = 0;
    logic       m_valid = 1'b0;
    logic [7:0] m_data = 8'h00;
    logic       m_fe = 1'b0;
    logic       m_ov = 1'b0;
    bit         rand_ready = 1'b0;
    int         fe_count = 0;
    int         ov_count = 0;
    int         rise_count = 0;
    int         last_rise_cyc = 0;
    int         last_start = 0;
    logic [7:0] last_rise_data = 8'h00;
    logic       prev_valid = 1'b0;

    serial_rx_uart #(
        .DIVISOR(D)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .serial_rx(serial_rx),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .frame_err(frame_err),
        .overrun  (overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Each frame the bench sends becomes one scheduled outcome (byte or
    // framing error) at its stop-sample edge; the model applies the
    // holding-register rules to those outcomes.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid = 1'b0;
            m_data  = 8'h00;
            m_fe    = 1'b0;
            m_ov    = 1'b0;
        end else begin
            m_fe = 1'b0;
            m_ov = 1'b0;
            mdel = 1'b0;
            if (evq.size() > 0 && evq[0].t == cyc + 1) begin
                mev = evq.pop_front();
                if (mev.err) m_fe = 1'b1;
                else         mdel = 1'b1;
            end
            if (mdel) begin
                if (!m_valid || rx_ready) begin
                    m_valid = 1'b1;
                    m_data  = mev.d;
                end else begin
                    m_ov = 1'b1;
                end
            end else if (m_valid && rx_ready) begin
                m_valid = 1'b0;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic stepCycle(input logic pin);
        @(negedge clk);
        if (rst_n) begin
            tests++;
            if (rx_valid !== m_valid || (m_valid && rx_data !== m_data) ||
                frame_err !== m_fe || overrun !== m_ov) begin
                fails++;
                $display("[TB] FAIL cycle %0d: dut valid=%b data=%h fe=%b ov=%b, model valid=%b data=%h fe=%b ov=%b",
                         cyc, rx_valid, rx_data, frame_err, overrun, m_valid, m_data, m_fe, m_ov);
            end
        end
        if (frame_err === 1'b1) fe_count++;
        if (overrun === 1'b1) ov_count++;
        if (rx_valid === 1'b1 && prev_valid !== 1'b1) begin
            rise_count++;
            last_rise_cyc  = cyc;
            last_rise_data = rx_data;
        end
        prev_valid = rx_valid;
        @(posedge clk);
        #1;
        serial_rx = pin;
        if (rand_ready) rx_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic idle(input int n);
        repeat (n) stepCycle(1'b1);
    endtask

    task automatic holdLow(input int n);
        repeat (n) stepCycle(1'b0);
    endtask

    // Sends one complete frame; pulse_ready raises rx_ready for exactly the
    // edge at which this frame's stop bit is sampled.
    task automatic applyStimulus(input logic [7:0] data, input logic stop, input bit pulse_ready);
        logic [9:0] fr;
        ev_t        e;
        fr = {stop, data, 1'b0};
        for (int i = 0; i < 10 * D; i++) begin
            stepCycle(fr[i/D]);
            if (i == 0) begin
                last_start = cyc;
                e.t   = cyc + TICK_OFS;
                e.err = !stop;
                e.d   = data;
                evq.push_back(e);
            end
            if (pulse_ready && i == TICK_OFS - 1) rx_ready = 1'b1;
            if (pulse_ready && i == TICK_OFS)     rx_ready = 1'b0;
        end
    endtask

    initial begin
        logic [9:0] fr9a;
        int         fe0;
        int         ov0;
        int         r0;
        logic [7:0] b;
        logic       stp;

        rst_n     = 1'b0;
        serial_rx = 1'b1;
        rx_ready  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset rx_data", rx_data, 8'h00);
        checkOutput("reset rx_valid", rx_valid, 1'b0);
        checkOutput("reset frame_err", frame_err, 1'b0);
        checkOutput("reset overrun", overrun, 1'b0);
        rst_n    = 1'b1;
        rx_ready = 1'b1;
        idle(2 * D);

        // Single byte, latency from the start edge to rx_valid
        r0 = rise_count;
        applyStimulus(8'hA5, 1'b1, 1'b0);
        idle(4);
        checkOutput("single latency", last_rise_cyc - last_start, 155);
        checkOutput("single data", last_rise_data, 8'hA5);
        checkOutput("single deliveries", rise_count - r0, 1);

        // Back-to-back frames with no idle gap
        r0 = rise_count;
        applyStimulus(8'h00, 1'b1, 1'b0);
        applyStimulus(8'hFF, 1'b1, 1'b0);
        applyStimulus(8'h3C, 1'b1, 1'b0);
        idle(4);
        checkOutput("b2b deliveries", rise_count - r0, 3);
        checkOutput("b2b last data", last_rise_data, 8'h3C);

        // Framing error followed by a long break
        r0  = rise_count;
        fe0 = fe_count;
        applyStimulus(8'h55, 1'b0, 1'b0);
        holdLow(39 * D);
        idle(2 * D);
        checkOutput("break frame_err count", fe_count - fe0, 1);
        checkOutput("break deliveries", rise_count - r0, 0);
        applyStimulus(8'h12, 1'b1, 1'b0);
        idle(4);
        checkOutput("after break data", last_rise_data, 8'h12);

        // Overrun while the holding register is full
        rx_ready = 1'b0;
        ov0 = ov_count;
        applyStimulus(8'h11, 1'b1, 1'b0);
        applyStimulus(8'h22, 1'b1, 1'b0);
        checkOutput("overrun held valid", rx_valid, 1'b1);
        checkOutput("overrun held data", rx_data, 8'h11);
        checkOutput("overrun pulses", ov_count - ov0, 1);
        rx_ready = 1'b1;
        idle(4);
        checkOutput("overrun drained", rx_valid, 1'b0);

        // Short glitch on an idle line
        r0  = rise_count;
        fe0 = fe_count;
        holdLow(3);
        idle(3 * D);
        checkOutput("glitch deliveries", rise_count - r0, 0);
        checkOutput("glitch frame_err", fe_count - fe0, 0);

        // Accept of the held byte in the same cycle a new one completes
        rx_ready = 1'b0;
        ov0 = ov_count;
        applyStimulus(8'h66, 1'b1, 1'b0);
        applyStimulus(8'h77, 1'b1, 1'b1);
        checkOutput("simul valid", rx_valid, 1'b1);
        checkOutput("simul data", rx_data, 8'h77);
        checkOutput("simul no overrun", ov_count - ov0, 0);
        rx_ready = 1'b1;
        idle(4);

        // Reset in the middle of a frame while a byte is held
        rx_ready = 1'b0;
        applyStimulus(8'h5A, 1'b1, 1'b0);
        checkOutput("pre-reset held", rx_valid, 1'b1);
        fr9a = {1'b1, 8'h9A, 1'b0};
        for (int i = 0; i <= 5 * D + H; i++) stepCycle(fr9a[i/D]);
        #2;
        rst_n = 1'b0;
        evq.delete();
        #1;
        checkOutput("midreset rx_data", rx_data, 8'h00);
        checkOutput("midreset rx_valid", rx_valid, 1'b0);
        checkOutput("midreset frame_err", frame_err, 1'b0);
        checkOutput("midreset overrun", overrun, 1'b0);
        idle(4);
        rst_n    = 1'b1;
        rx_ready = 1'b1;
        idle(2 * D);
        fe0 = fe_count;
        applyStimulus(8'hC3, 1'b1, 1'b0);
        idle(4);
        checkOutput("post-reset data", last_rise_data, 8'hC3);
        checkOutput("post-reset frame_err", fe_count - fe0, 0);

        // Random frames, gaps, stop bits and consumer readiness
        rand_ready = 1'b1;
        repeat (30) begin
            b   = 8'($urandom);
            stp = ($urandom_range(0, 7) != 0);
            applyStimulus(b, stp, 1'b0);
            if (!stp) begin
                holdLow(D * $urandom_range(1, 5));
                idle(D + 4);
            end else begin
                idle($urandom_range(0, D));
            end
        end
        rand_ready = 1'b0;
        rx_ready   = 1'b1;
        idle(3 * D);
        checkOutput("events drained", evq.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
